// File: rtl/pa_lsu_icc_ctrl_if.sv
// ----------------------------------------------------------------------------
// pa_lsu_icc_ctrl_if
// Bundles the signals around the dcache-maintenance responder:
//   CP0 request/done     : ext_inst_lsu_icc_req/type/op/addr, ext_inst_lsu_icc_done
//   LSU status           : lsu_icc_busy
//   tag array port       : lsu_icc_tag_req/wen/idx/way/wdata, lsu_icc_tag_gnt,
//                          lsu_icc_tag_rdata_w0/w1
//   writeback path       : lsu_icc_wb_req/idx/way, lsu_icc_wb_ack
// slave  : the responder (pa_lsu_icc_ctrl)
// master : the environment around it (CP0, tag arbiter, writeback unit)
// ----------------------------------------------------------------------------
interface pa_lsu_icc_ctrl_if #(
  parameter int unsigned INDEX_W = 7,
  parameter int unsigned TAG_W   = 21
);
  logic               ext_inst_lsu_icc_req;
  logic [1:0]         ext_inst_lsu_icc_type;
  logic [1:0]         ext_inst_lsu_icc_op;
  logic [31:0]        ext_inst_lsu_icc_addr;
  logic               ext_inst_lsu_icc_done;
  logic               lsu_icc_busy;
  logic               lsu_icc_tag_req;
  logic               lsu_icc_tag_wen;
  logic [INDEX_W-1:0] lsu_icc_tag_idx;
  logic               lsu_icc_tag_way;
  logic [1:0]         lsu_icc_tag_wdata;
  logic               lsu_icc_tag_gnt;
  logic [TAG_W+1:0]   lsu_icc_tag_rdata_w0;
  logic [TAG_W+1:0]   lsu_icc_tag_rdata_w1;
  logic               lsu_icc_wb_req;
  logic [INDEX_W-1:0] lsu_icc_wb_idx;
  logic               lsu_icc_wb_way;
  logic               lsu_icc_wb_ack;

  modport slave (
    input  ext_inst_lsu_icc_req, ext_inst_lsu_icc_type, ext_inst_lsu_icc_op,
           ext_inst_lsu_icc_addr, lsu_icc_tag_gnt, lsu_icc_tag_rdata_w0,
           lsu_icc_tag_rdata_w1, lsu_icc_wb_ack,
    output ext_inst_lsu_icc_done, lsu_icc_busy, lsu_icc_tag_req, lsu_icc_tag_wen,
           lsu_icc_tag_idx, lsu_icc_tag_way, lsu_icc_tag_wdata, lsu_icc_wb_req,
           lsu_icc_wb_idx, lsu_icc_wb_way
  );

  modport master (
    output ext_inst_lsu_icc_req, ext_inst_lsu_icc_type, ext_inst_lsu_icc_op,
           ext_inst_lsu_icc_addr, lsu_icc_tag_gnt, lsu_icc_tag_rdata_w0,
           lsu_icc_tag_rdata_w1, lsu_icc_wb_ack,
    input  ext_inst_lsu_icc_done, lsu_icc_busy, lsu_icc_tag_req, lsu_icc_tag_wen,
           lsu_icc_tag_idx, lsu_icc_tag_way, lsu_icc_tag_wdata, lsu_icc_wb_req,
           lsu_icc_wb_idx, lsu_icc_wb_way
  );
endinterface

// File: rtl/pa_lsu_icc_ctrl.sv
// ----------------------------------------------------------------------------
// pa_lsu_icc_ctrl
// Dcache-maintenance responder: walks the 2-way dcache tag array (all lines,
// one set/way, or a PA lookup), writes dirty lines back and cleans and/or
// invalidates them, then pulses done to CP0.
// Ports:
//   forever_cpuclk : clock
//   cpurst_b       : asynchronous reset, active low
//   icc            : pa_lsu_icc_ctrl_if.slave (CP0 request, tag port, writeback)
// All outputs are registered.
// ----------------------------------------------------------------------------
module pa_lsu_icc_ctrl #(
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned INDEX_W  = 7,
  parameter int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  pa_lsu_icc_ctrl_if.slave  icc
);

  localparam int unsigned LINE_W = TAG_W + 2;
  localparam logic [INDEX_W-1:0] LAST_SET = '1;
  localparam logic [1:0] TYPE_SETWAY = 2'b01;
  localparam logic [1:0] TYPE_PA     = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_TAG_RD, S_TAG_CHK, S_WB, S_TAG_WR, S_NEXT, S_DONE
  } state_e;

  state_e             state_q;
  logic [1:0]         type_q;
  logic [1:0]         op_q;
  logic [TAG_W-1:0]   atag_q;
  logic [INDEX_W-1:0] set_q;
  logic               way_q;
  logic               sel_way_q;
  logic               wrote_q;
  logic               fresh_q;
  logic [LINE_W-1:0]  line0_q;
  logic [LINE_W-1:0]  line1_q;

  logic               done_q;
  logic               busy_q;
  logic               tag_req_q;
  logic               tag_wen_q;
  logic               tag_way_q;
  logic [1:0]         tag_wdata_q;
  logic               wb_req_q;
  logic [INDEX_W-1:0] wb_idx_q;
  logic               wb_way_q;

  // Type 11 is treated as ALL.
  logic req_all_c;
  logic is_all_c;
  logic is_pa_c;
  assign req_all_c = (icc.ext_inst_lsu_icc_type != TYPE_SETWAY) &&
                     (icc.ext_inst_lsu_icc_type != TYPE_PA);
  assign is_all_c  = (type_q != TYPE_SETWAY) && (type_q != TYPE_PA);
  assign is_pa_c   = (type_q == TYPE_PA);

  // Fresh read data right after a granted read; otherwise the copy kept from
  // the previous check (way-1 pass of an ALL walk without an intervening write).
  logic [LINE_W-1:0] line0_c;
  logic [LINE_W-1:0] line1_c;
  assign line0_c = fresh_q ? icc.lsu_icc_tag_rdata_w0 : line0_q;
  assign line1_c = fresh_q ? icc.lsu_icc_tag_rdata_w1 : line1_q;

  // Line selection and action decode for TAG_CHK.
  logic hit0_c, hit1_c, pa_miss_c, chk_way_c, chk_v_c, chk_d_c;
  logic need_wb_c, need_wr_c;
  logic [1:0] wdata_c;
  assign hit0_c    = line0_c[LINE_W-1] && (line0_c[TAG_W-1:0] == atag_q);
  assign hit1_c    = line1_c[LINE_W-1] && (line1_c[TAG_W-1:0] == atag_q);
  assign pa_miss_c = is_pa_c && !hit0_c && !hit1_c;
  assign chk_way_c = is_pa_c ? !hit0_c : way_q;
  assign chk_v_c   = chk_way_c ? line1_c[LINE_W-1] : line0_c[LINE_W-1];
  assign chk_d_c   = chk_way_c ? line1_c[LINE_W-2] : line0_c[LINE_W-2];
  assign need_wb_c = op_q[0] && chk_v_c && chk_d_c;
  assign need_wr_c = op_q[1] ? chk_v_c : need_wb_c;
  assign wdata_c   = op_q[1] ? 2'b00 : 2'b10;

  // Single-line operations finish straight after their line; only the ALL
  // walk goes through NEXT to advance the set/way counters.
  state_e adv_state_c;
  assign adv_state_c = is_all_c ? S_NEXT : S_DONE;

  // Maintenance FSM with registered outputs.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= S_IDLE;
      type_q      <= '0;
      op_q        <= '0;
      atag_q      <= '0;
      set_q       <= '0;
      way_q       <= 1'b0;
      sel_way_q   <= 1'b0;
      wrote_q     <= 1'b0;
      fresh_q     <= 1'b0;
      line0_q     <= '0;
      line1_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      tag_req_q   <= 1'b0;
      tag_wen_q   <= 1'b0;
      tag_way_q   <= 1'b0;
      tag_wdata_q <= '0;
      wb_req_q    <= 1'b0;
      wb_idx_q    <= '0;
      wb_way_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (icc.ext_inst_lsu_icc_req) begin
            type_q  <= icc.ext_inst_lsu_icc_type;
            op_q    <= icc.ext_inst_lsu_icc_op;
            atag_q  <= icc.ext_inst_lsu_icc_addr[31 -: TAG_W];
            set_q   <= req_all_c ? '0 : icc.ext_inst_lsu_icc_addr[OFFSET_W +: INDEX_W];
            way_q   <= (icc.ext_inst_lsu_icc_type == TYPE_SETWAY) ?
                       icc.ext_inst_lsu_icc_addr[31] : 1'b0;
            wrote_q <= 1'b0;
            busy_q  <= 1'b1;
            if (icc.ext_inst_lsu_icc_op == 2'b00) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_TAG_RD;
              tag_req_q <= 1'b1;
              tag_wen_q <= 1'b0;
            end
          end
        end

        S_TAG_RD: begin
          if (icc.lsu_icc_tag_gnt) begin
            tag_req_q <= 1'b0;
            fresh_q   <= 1'b1;
            state_q   <= S_TAG_CHK;
          end
        end

        S_TAG_CHK: begin
          fresh_q   <= 1'b0;
          line0_q   <= line0_c;
          line1_q   <= line1_c;
          sel_way_q <= chk_way_c;
          if (pa_miss_c) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (need_wb_c) begin
            state_q  <= S_WB;
            wb_req_q <= 1'b1;
            wb_idx_q <= set_q;
            wb_way_q <= chk_way_c;
          end else if (need_wr_c) begin
            state_q     <= S_TAG_WR;
            tag_req_q   <= 1'b1;
            tag_wen_q   <= 1'b1;
            tag_way_q   <= chk_way_c;
            tag_wdata_q <= wdata_c;
          end else begin
            state_q <= adv_state_c;
            done_q  <= !is_all_c;
          end
        end

        S_WB: begin
          if (icc.lsu_icc_wb_ack) begin
            wb_req_q    <= 1'b0;
            state_q     <= S_TAG_WR;
            tag_req_q   <= 1'b1;
            tag_wen_q   <= 1'b1;
            tag_way_q   <= sel_way_q;
            tag_wdata_q <= wdata_c;
          end
        end

        S_TAG_WR: begin
          if (icc.lsu_icc_tag_gnt) begin
            tag_req_q <= 1'b0;
            tag_wen_q <= 1'b0;
            wrote_q   <= 1'b1;
            state_q   <= adv_state_c;
            done_q    <= !is_all_c;
          end
        end

        S_NEXT: begin
          if (!way_q) begin
            way_q <= 1'b1;
            // A write to way 0 makes the held read stale by policy: re-read.
            if (wrote_q) begin
              wrote_q   <= 1'b0;
              state_q   <= S_TAG_RD;
              tag_req_q <= 1'b1;
            end else begin
              state_q <= S_TAG_CHK;
            end
          end else if (set_q == LAST_SET) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            set_q     <= set_q + INDEX_W'(1);
            way_q     <= 1'b0;
            wrote_q   <= 1'b0;
            state_q   <= S_TAG_RD;
            tag_req_q <= 1'b1;
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign icc.ext_inst_lsu_icc_done = done_q;
  assign icc.lsu_icc_busy          = busy_q;
  assign icc.lsu_icc_tag_req       = tag_req_q;
  assign icc.lsu_icc_tag_wen       = tag_wen_q;
  assign icc.lsu_icc_tag_idx       = set_q;
  assign icc.lsu_icc_tag_way       = tag_way_q;
  assign icc.lsu_icc_tag_wdata     = tag_wdata_q;
  assign icc.lsu_icc_wb_req        = wb_req_q;
  assign icc.lsu_icc_wb_idx        = wb_idx_q;
  assign icc.lsu_icc_wb_way        = wb_way_q;

endmodule

// File: tb/tb_pa_lsu_icc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pa_lsu_icc_ctrl
// Directed, table-driven bench for pa_lsu_icc_ctrl. The bench plays CP0, the
// tag arbiter (grant, optional stall) and the writeback unit (ack after a
// programmable delay). Cycle 0 is the cycle in which req is first seen.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pa_lsu_icc_ctrl;

  localparam int unsigned INDEX_W = 7;
  localparam int unsigned TAG_W   = 21;
  localparam int          BUDGET  = 3000;

  localparam logic [TAG_W-1:0] TAGV  = 21'h0ABCD;
  localparam logic [TAG_W-1:0] OTHER = 21'h12345;
  localparam logic [31:0] A_PA  = {TAGV, 7'd5, 4'h8};
  localparam logic [31:0] A_SW1 = {1'b1, 20'h0, 7'd5, 4'h0};
  localparam logic [31:0] A_SW0 = {1'b0, 20'h0, 7'd5, 4'h0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pa_lsu_icc_ctrl_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) icc ();

  pa_lsu_icc_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .icc            (icc)
  );

  typedef struct {
    string       name;
    logic [1:0]  typ;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [22:0] w0;
    logic [22:0] w1;
    int          stall;
    int          ack_dly;
    bit          drop;
    int          e_done;
    int          e_nwr;
    logic        e_wway;
    logic [1:0]  e_wdata;
    int          e_nwb;
    int          e_wbcyc;
    logic        e_wbway;
  } vec_t;

  typedef struct packed {
    logic [6:0] idx;
    logic       way;
    logic [1:0] wdata;
  } wr_t;

  int n_chk  = 0;
  int n_pass = 0;

  wr_t wr_log[$];
  int   r_done, r_ndone, r_nwb, r_wbcyc;
  logic r_busy_done, r_busy_after, r_wbway;
  logic [6:0] r_wbidx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [22:0] outs();
    return {icc.ext_inst_lsu_icc_done, icc.lsu_icc_busy, icc.lsu_icc_tag_req,
            icc.lsu_icc_tag_wen, icc.lsu_icc_tag_idx, icc.lsu_icc_tag_way,
            icc.lsu_icc_tag_wdata, icc.lsu_icc_wb_req, icc.lsu_icc_wb_idx,
            icc.lsu_icc_wb_way};
  endfunction

  // Issue one request and act as arbiter/writeback unit until done + 2 cycles.
  task automatic run_op(input vec_t v);
    int   stall_left = v.stall;
    int   ack_cnt    = 0;
    logic prev_wb    = 1'b0;
    logic gnt_v;
    wr_log.delete();
    r_done = -1; r_ndone = 0; r_nwb = 0; r_wbcyc = 0;
    r_busy_done = 1'b0; r_busy_after = 1'b1; r_wbidx = '0; r_wbway = 1'b0;
    icc.lsu_icc_tag_rdata_w0 = v.w0;
    icc.lsu_icc_tag_rdata_w1 = v.w1;
    @(negedge clk);
    icc.ext_inst_lsu_icc_req  = 1'b1;
    icc.ext_inst_lsu_icc_type = v.typ;
    icc.ext_inst_lsu_icc_op   = v.op;
    icc.ext_inst_lsu_icc_addr = v.addr;
    icc.lsu_icc_tag_gnt       = 1'b1;
    icc.lsu_icc_wb_ack        = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      if (icc.lsu_icc_tag_req && !icc.lsu_icc_tag_wen && stall_left > 0) begin
        gnt_v = 1'b0;
        stall_left--;
      end else begin
        gnt_v = 1'b1;
      end
      icc.lsu_icc_tag_gnt = gnt_v;
      if (icc.lsu_icc_tag_req && icc.lsu_icc_tag_wen && gnt_v)
        wr_log.push_back({icc.lsu_icc_tag_idx, icc.lsu_icc_tag_way, icc.lsu_icc_tag_wdata});
      if (icc.lsu_icc_wb_req) begin
        if (!prev_wb) r_nwb++;
        r_wbcyc++;
        r_wbidx = icc.lsu_icc_wb_idx;
        r_wbway = icc.lsu_icc_wb_way;
        icc.lsu_icc_wb_ack = (ack_cnt == v.ack_dly);
        ack_cnt++;
      end else begin
        icc.lsu_icc_wb_ack = 1'b0;
        ack_cnt = 0;
      end
      prev_wb = icc.lsu_icc_wb_req;
      if (v.drop && k == 2) icc.ext_inst_lsu_icc_req = 1'b0;
      if (icc.ext_inst_lsu_icc_done) begin
        r_ndone++;
        if (r_done < 0) begin
          r_done      = k;
          r_busy_done = icc.lsu_icc_busy;
        end
        icc.ext_inst_lsu_icc_req = 1'b0;
      end
      if (r_done >= 0 && k == r_done + 2) begin
        r_busy_after = icc.lsu_icc_busy;
        break;
      end
    end
    icc.ext_inst_lsu_icc_req = 1'b0;
    icc.lsu_icc_tag_gnt      = 1'b1;
    icc.lsu_icc_wb_ack       = 1'b0;
  endtask

  task automatic check_vec(input vec_t v);
    check({v.name, " done_cycle"}, 64'(r_done), 64'(v.e_done));
    check({v.name, " done_pulses"}, 64'(r_ndone), 64'd1);
    check({v.name, " busy_at_done"}, 64'(r_busy_done), 64'd1);
    check({v.name, " busy_after"}, 64'(r_busy_after), 64'd0);
    check({v.name, " tag_writes"}, 64'(wr_log.size()), 64'(v.e_nwr));
    if (v.e_nwr == 1 && wr_log.size() == 1)
      check({v.name, " tag_write_fields"}, 64'(wr_log[0]), 64'({7'd5, v.e_wway, v.e_wdata}));
    check({v.name, " wb_reqs"}, 64'(r_nwb), 64'(v.e_nwb));
    check({v.name, " wb_req_cycles"}, 64'(r_wbcyc), 64'(v.e_wbcyc));
    if (v.e_nwb > 0)
      check({v.name, " wb_target"}, 64'({r_wbidx, r_wbway}), 64'({7'd5, v.e_wbway}));
  endtask

  vec_t vecs[11];
  vec_t va;

  initial begin
    vecs[0]  = '{"pa_inval_hit_w1",   2'b10, 2'b10, A_PA,  {1'b1,1'b0,OTHER}, {1'b1,1'b0,TAGV},  0, 0, 1'b0, 4,  1, 1'b1, 2'b00, 0, 0, 1'b0};
    vecs[1]  = '{"pa_clean_miss",     2'b10, 2'b01, A_PA,  {1'b1,1'b1,OTHER}, {1'b0,1'b1,TAGV},  0, 0, 1'b0, 3,  0, 1'b0, 2'b00, 0, 0, 1'b0};
    vecs[2]  = '{"sw_cln_inv_dirty",  2'b01, 2'b11, A_SW1, {1'b0,1'b0,OTHER}, {1'b1,1'b1,OTHER}, 0, 2, 1'b1, 7,  1, 1'b1, 2'b00, 1, 3, 1'b1};
    vecs[3]  = '{"pa_clean_w0_prio",  2'b10, 2'b01, A_PA,  {1'b1,1'b1,TAGV},  {1'b1,1'b1,TAGV},  0, 0, 1'b0, 5,  1, 1'b0, 2'b10, 1, 1, 1'b0};
    vecs[4]  = '{"sw_clean_line",     2'b01, 2'b01, A_SW0, {1'b1,1'b0,OTHER}, {1'b1,1'b1,OTHER}, 0, 0, 1'b0, 3,  0, 1'b0, 2'b00, 0, 0, 1'b0};
    vecs[5]  = '{"sw_inval_invalid",  2'b01, 2'b10, A_SW1, {1'b1,1'b1,OTHER}, {1'b0,1'b1,OTHER}, 0, 0, 1'b0, 3,  0, 1'b0, 2'b00, 0, 0, 1'b0};
    vecs[6]  = '{"sw_inval_valid",    2'b01, 2'b10, A_SW0, {1'b1,1'b0,OTHER}, {1'b0,1'b0,OTHER}, 0, 0, 1'b0, 4,  1, 1'b0, 2'b00, 0, 0, 1'b0};
    vecs[7]  = '{"op_none",           2'b01, 2'b00, A_SW1, {1'b1,1'b1,OTHER}, {1'b1,1'b1,OTHER}, 0, 0, 1'b0, 1,  0, 1'b0, 2'b00, 0, 0, 1'b0};
    vecs[8]  = '{"grant_stall",       2'b01, 2'b01, A_SW0, {1'b1,1'b0,OTHER}, {1'b1,1'b1,OTHER}, 10, 0, 1'b0, 13, 0, 1'b0, 2'b00, 0, 0, 1'b0};
    vecs[9]  = '{"sw_clean_dirty",    2'b01, 2'b01, A_SW0, {1'b1,1'b1,OTHER}, {1'b0,1'b0,OTHER}, 0, 1, 1'b0, 6,  1, 1'b0, 2'b10, 1, 2, 1'b0};
    vecs[10] = '{"pa_inval_dirty",    2'b10, 2'b10, A_PA,  {1'b1,1'b1,TAGV},  {1'b0,1'b0,OTHER}, 0, 0, 1'b0, 4,  1, 1'b0, 2'b00, 0, 0, 1'b0};

    rst_n = 1'b0;
    icc.ext_inst_lsu_icc_req  = 1'b0;
    icc.ext_inst_lsu_icc_type = 2'b00;
    icc.ext_inst_lsu_icc_op   = 2'b00;
    icc.ext_inst_lsu_icc_addr = '0;
    icc.lsu_icc_tag_gnt       = 1'b1;
    icc.lsu_icc_tag_rdata_w0  = '0;
    icc.lsu_icc_tag_rdata_w1  = '0;
    icc.lsu_icc_wb_ack        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outs()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", 64'(outs()), 64'd0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i]);
      check_vec(vecs[i]);
    end

    // Full walk, invalidate: 256 writes in set/way order, 8 cycles per set.
    va = '{"all_inval", 2'b00, 2'b10, 32'h0, {1'b1,1'b0,OTHER}, {1'b1,1'b0,OTHER}, 0, 0, 1'b0, 1025, 256, 1'b0, 2'b00, 0, 0, 1'b0};
    run_op(va);
    check_vec(va);
    begin
      int bad = 0;
      foreach (wr_log[i])
        if (wr_log[i] !== {7'(i / 2), 1'(i % 2), 2'b00}) bad++;
      check("all_inval_order", 64'(bad), 64'd0);
    end

    // Type 11 walks everything; clean lines reuse the read for way 1 (5 cycles per set).
    va = '{"all_clean_t3", 2'b11, 2'b01, 32'hFFFF_FFF0, {1'b1,1'b0,OTHER}, {1'b1,1'b0,OTHER}, 0, 0, 1'b0, 641, 0, 1'b0, 2'b00, 0, 0, 1'b0};
    run_op(va);
    check_vec(va);

    // Reset while a writeback is outstanding.
    begin
      bit seen = 1'b0;
      int nd   = 0;
      icc.lsu_icc_tag_rdata_w0 = '0;
      icc.lsu_icc_tag_rdata_w1 = {1'b1, 1'b1, OTHER};
      @(negedge clk);
      icc.ext_inst_lsu_icc_req  = 1'b1;
      icc.ext_inst_lsu_icc_type = 2'b01;
      icc.ext_inst_lsu_icc_op   = 2'b11;
      icc.ext_inst_lsu_icc_addr = A_SW1;
      icc.lsu_icc_wb_ack        = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (icc.lsu_icc_wb_req) begin
          seen = 1'b1;
          break;
        end
      end
      check("rst_wb_reached", 64'(seen), 64'd1);
      #2;
      rst_n = 1'b0;
      icc.ext_inst_lsu_icc_req = 1'b0;
      #1;
      check("rst_async_outputs", 64'(outs()), 64'd0);
      repeat (3) begin
        @(negedge clk);
        if (icc.ext_inst_lsu_icc_done) nd++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      if (icc.ext_inst_lsu_icc_done) nd++;
      check("rst_no_done", 64'(nd), 64'd0);
    end
    run_op(vecs[0]);
    check_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
